// File: rtl/motor_step_engine.sv
// motor_step_engine
// N-channel step/direction pulse generator for the t_motors pin bundle.
// Each channel runs its own motion FSM. Move commands (steps, direction,
// half-period, boost) arrive over one shared valid/ready port. A channel
// stops early on its direction-specific end switch, on power fail, or on
// abort, and records which cause stopped it.
//
// Ports
//   clk_ik, rst_in                    clock, async active-low reset
//   cmd_valid_i / cmd_ready_o         command handshake (ready is combinational)
//   cmd_ch_ib                         target channel, 0-based
//   cmd_steps_ib, cmd_dir_i,
//   cmd_hp_ib, cmd_boost_i            move parameters
//   abort_ib                          per-channel stop request (synchronous)
//   pl_clk_ob, pl_dir_ob,
//   pl_en_ob, pl_boost_ob             motor board pins
//   pl_pfail_ib, pl_sw_outa_ib,
//   pl_sw_outb_ib                     asynchronous pin inputs
//   busy_ob, done_ob                  channel not idle / one-cycle end-of-move
//   endsw_ob, fault_ob, aborted_ob    sticky stop-cause flags
//
// Channel FSM
//   state   | meaning
//   S_IDLE  | waiting for a command, pins quiet except pl_dir
//   S_SETUP | direction/enable settling for DIR_SETUP cycles
//   S_HIGH  | pl_clk high for hp cycles
//   S_LOW   | pl_clk low for hp cycles, remaining count already decremented
//   S_DONE  | single cycle, pulses done_ob

module motor_step_engine #(
   parameter int NUM_MOTORS = 16,
   parameter int STEP_W     = 32,
   parameter int HP_W       = 16,
   parameter int DIR_SETUP  = 8,
   localparam int CH_W      = (NUM_MOTORS > 1) ? $clog2(NUM_MOTORS) : 1
) (
   input  logic                  clk_ik,
   input  logic                  rst_in,
   input  logic                  cmd_valid_i,
   output logic                  cmd_ready_o,
   input  logic [CH_W-1:0]       cmd_ch_ib,
   input  logic [STEP_W-1:0]     cmd_steps_ib,
   input  logic                  cmd_dir_i,
   input  logic [HP_W-1:0]       cmd_hp_ib,
   input  logic                  cmd_boost_i,
   input  logic [NUM_MOTORS-1:0] abort_ib,
   output logic [NUM_MOTORS-1:0] pl_clk_ob,
   output logic [NUM_MOTORS-1:0] pl_dir_ob,
   output logic [NUM_MOTORS-1:0] pl_en_ob,
   output logic [NUM_MOTORS-1:0] pl_boost_ob,
   input  logic [NUM_MOTORS-1:0] pl_pfail_ib,
   input  logic [NUM_MOTORS-1:0] pl_sw_outa_ib,
   input  logic [NUM_MOTORS-1:0] pl_sw_outb_ib,
   output logic [NUM_MOTORS-1:0] busy_ob,
   output logic [NUM_MOTORS-1:0] done_ob,
   output logic [NUM_MOTORS-1:0] endsw_ob,
   output logic [NUM_MOTORS-1:0] fault_ob,
   output logic [NUM_MOTORS-1:0] aborted_ob
);

   localparam int SET_W = $clog2(DIR_SETUP + 1);
   localparam int TMR_W = (HP_W > SET_W) ? HP_W : SET_W;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SETUP = 3'd1,
      S_HIGH  = 3'd2,
      S_LOW   = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   // Reset asserts asynchronously and releases on a clock edge.
   logic [1:0] rst_sync;
   logic       rst_b;

   always_ff @(posedge clk_ik or negedge rst_in) begin
      if (!rst_in) rst_sync <= 2'b00;
      else         rst_sync <= {rst_sync[0], 1'b1};
   end

   assign rst_b = rst_sync[1];

   logic [NUM_MOTORS-1:0] pfail_m, pfail_s;
   logic [NUM_MOTORS-1:0] swa_m, swa_s;
   logic [NUM_MOTORS-1:0] swb_m, swb_s;

   always_ff @(posedge clk_ik or negedge rst_b) begin
      if (!rst_b) begin
         pfail_m <= '0;
         pfail_s <= '0;
         swa_m   <= '0;
         swa_s   <= '0;
         swb_m   <= '0;
         swb_s   <= '0;
      end else begin
         pfail_m <= pl_pfail_ib;
         pfail_s <= pfail_m;
         swa_m   <= pl_sw_outa_ib;
         swa_s   <= swa_m;
         swb_m   <= pl_sw_outb_ib;
         swb_s   <= swb_m;
      end
   end

   // Command decode. Out-of-range channel indices match no channel and so
   // are never ready.
   logic [NUM_MOTORS-1:0] idle_vec;
   logic [NUM_MOTORS-1:0] sel;
   logic [NUM_MOTORS-1:0] accept;

   always_comb begin
      cmd_ready_o = 1'b0;
      sel         = '0;
      for (int i = 0; i < NUM_MOTORS; i++) begin
         if (cmd_ch_ib == CH_W'(i)) begin
            sel[i]      = 1'b1;
            cmd_ready_o = idle_vec[i];
         end
      end
   end

   assign accept = sel & {NUM_MOTORS{cmd_valid_i & cmd_ready_o}};

   // Timer reload for one pl_clk phase; a half-period of 0 runs as 1.
   logic [HP_W-1:0] hp_ld;
   assign hp_ld = (cmd_hp_ib == '0) ? '0 : cmd_hp_ib - HP_W'(1);

   for (genvar g = 0; g < NUM_MOTORS; g++) begin : g_ch
      state_t            state, state_nxt;
      logic [TMR_W-1:0]  tmr, tmr_nxt;
      logic [STEP_W-1:0] rem, rem_nxt;
      logic [HP_W-1:0]   hp_q;
      logic              dir_q, boost_q;
      logic              endsw_q, fault_q, abort_q;
      logic              set_endsw, set_fault, set_abort;
      logic              sw_hit;

      assign sw_hit = dir_q ? swa_s[g] : swb_s[g];

      always_ff @(posedge clk_ik or negedge rst_b) begin
         if (!rst_b) begin
            state <= S_IDLE;
            tmr   <= '0;
            rem   <= '0;
         end else begin
            state <= state_nxt;
            tmr   <= tmr_nxt;
            rem   <= rem_nxt;
         end
      end

      // Stop causes are ranked pfail > abort > end switch. pfail and abort
      // act in any cycle of an active move; the end switch is only looked
      // at where a new rising edge of pl_clk would be issued, so a pulse
      // already started always completes.
      always_comb begin
         state_nxt = state;
         tmr_nxt   = tmr;
         rem_nxt   = rem;
         set_endsw = 1'b0;
         set_fault = 1'b0;
         set_abort = 1'b0;
         case (state)
            S_IDLE: begin
               if (accept[g]) begin
                  state_nxt = S_SETUP;
                  tmr_nxt   = TMR_W'(DIR_SETUP - 1);
                  rem_nxt   = cmd_steps_ib;
               end
            end
            S_SETUP, S_HIGH, S_LOW: begin
               if (pfail_s[g]) begin
                  state_nxt = S_DONE;
                  set_fault = 1'b1;
               end else if (abort_ib[g]) begin
                  state_nxt = S_DONE;
                  set_abort = 1'b1;
               end else if (tmr != '0) begin
                  tmr_nxt = tmr - TMR_W'(1);
               end else if (state == S_HIGH) begin
                  state_nxt = S_LOW;
                  tmr_nxt   = TMR_W'(hp_q);
                  if (rem != '0) rem_nxt = rem - STEP_W'(1);
               end else if (rem == '0) begin
                  state_nxt = S_DONE;
               end else if (sw_hit) begin
                  state_nxt = S_DONE;
                  set_endsw = 1'b1;
               end else begin
                  state_nxt = S_HIGH;
                  tmr_nxt   = TMR_W'(hp_q);
               end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
         endcase
      end

      always_ff @(posedge clk_ik or negedge rst_b) begin
         if (!rst_b) begin
            dir_q   <= 1'b0;
            boost_q <= 1'b0;
            hp_q    <= '0;
            endsw_q <= 1'b0;
            fault_q <= 1'b0;
            abort_q <= 1'b0;
         end else if (accept[g]) begin
            dir_q   <= cmd_dir_i;
            boost_q <= cmd_boost_i;
            hp_q    <= hp_ld;
            endsw_q <= 1'b0;
            fault_q <= 1'b0;
            abort_q <= 1'b0;
         end else begin
            if (set_endsw) endsw_q <= 1'b1;
            if (set_fault) fault_q <= 1'b1;
            if (set_abort) abort_q <= 1'b1;
         end
      end

      assign idle_vec[g]    = (state == S_IDLE);
      assign pl_clk_ob[g]   = (state == S_HIGH);
      assign pl_dir_ob[g]   = dir_q;
      assign pl_en_ob[g]    = (state != S_IDLE);
      assign pl_boost_ob[g] = boost_q & ((state == S_HIGH) || (state == S_LOW));
      assign busy_ob[g]     = (state != S_IDLE);
      assign done_ob[g]     = (state == S_DONE);
      assign endsw_ob[g]    = endsw_q;
      assign fault_ob[g]    = fault_q;
      assign aborted_ob[g]  = abort_q;
   end

endmodule

// File: tb/tb_motor_step_engine.sv
// Bench for motor_step_engine. The DUT is built with 12 channels so that
// channel selects 12..15 exist on the 4-bit select and must never be ready.
// Cycle numbering: cyc is the count of rising edges so far; a command whose
// valid is offered in cycle k is accepted at edge k+1, and an event "at k+n"
// is the state registered at edge k+n.

module tb_motor_step_engine;

   localparam int NM = 12;

   logic          clk_ik = 1'b0;
   logic          rst_in = 1'b0;
   logic          cmd_valid_i;
   logic          cmd_ready_o;
   logic [3:0]    cmd_ch_ib;
   logic [31:0]   cmd_steps_ib;
   logic          cmd_dir_i;
   logic [15:0]   cmd_hp_ib;
   logic          cmd_boost_i;
   logic [NM-1:0] abort_ib;
   logic [NM-1:0] pl_clk_ob, pl_dir_ob, pl_en_ob, pl_boost_ob;
   logic [NM-1:0] pl_pfail_ib, pl_sw_outa_ib, pl_sw_outb_ib;
   logic [NM-1:0] busy_ob, done_ob, endsw_ob, fault_ob, aborted_ob;

   always #5 clk_ik = ~clk_ik;

   int cyc = 0;
   always @(posedge clk_ik) cyc <= cyc + 1;

   motor_step_engine #(
      .NUM_MOTORS(NM), .STEP_W(32), .HP_W(16), .DIR_SETUP(8)
   ) dut (
      .clk_ik(clk_ik), .rst_in(rst_in),
      .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
      .cmd_ch_ib(cmd_ch_ib), .cmd_steps_ib(cmd_steps_ib),
      .cmd_dir_i(cmd_dir_i), .cmd_hp_ib(cmd_hp_ib), .cmd_boost_i(cmd_boost_i),
      .abort_ib(abort_ib),
      .pl_clk_ob(pl_clk_ob), .pl_dir_ob(pl_dir_ob),
      .pl_en_ob(pl_en_ob), .pl_boost_ob(pl_boost_ob),
      .pl_pfail_ib(pl_pfail_ib), .pl_sw_outa_ib(pl_sw_outa_ib),
      .pl_sw_outb_ib(pl_sw_outb_ib),
      .busy_ob(busy_ob), .done_ob(done_ob), .endsw_ob(endsw_ob),
      .fault_ob(fault_ob), .aborted_ob(aborted_ob)
   );

   int n_checks = 0;
   int n_err    = 0;

   function automatic void check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endfunction

   typedef struct {
      int ch;
      int done_cyc;
      int rises;
      int first;   // cycle of first pl_clk rise, -1 when no pulse
      int hp;      // pulse width to verify, 0 to skip width checks
      bit endsw;
      bit fault;
      bit abrt;
   } exp_t;

   exp_t sb[$];

   function automatic void expect_done(input int ch, input int dc, input int r,
                                       input int f, input int hp,
                                       input bit es, input bit fl, input bit ab);
      exp_t e;
      e.ch = ch; e.done_cyc = dc; e.rises = r; e.first = f; e.hp = hp;
      e.endsw = es; e.fault = fl; e.abrt = ab;
      sb.push_back(e);
   endfunction

   // Monitor: per-channel pulse statistics, scored on each done_ob pulse.
   int rises [NM];
   int first_r [NM];
   int last_r [NM];
   int hi_len [NM];
   int hmin [NM];
   int hmax [NM];
   int pmin [NM];
   int pmax [NM];
   logic [NM-1:0] prev_clk;

   function automatic void clr_trk(input int c);
      rises[c] = 0; first_r[c] = -1; last_r[c] = -1; hi_len[c] = 0;
      hmin[c] = 1 << 30; hmax[c] = 0; pmin[c] = 1 << 30; pmax[c] = 0;
   endfunction

   function automatic void score(input int c);
      int   idx = -1;
      exp_t e;
      foreach (sb[i]) if (idx < 0 && sb[i].ch == c) idx = i;
      if (idx < 0) begin
         n_checks++;
         n_err++;
         $display("FAIL unexpected_done ch%0d: done pulse at cycle %0d, none expected", c, cyc);
         clr_trk(c);
         return;
      end
      e = sb[idx];
      sb.delete(idx);
      check($sformatf("done_cycle ch%0d", c), cyc, e.done_cyc);
      check($sformatf("pulse_count ch%0d", c), rises[c], e.rises);
      if (e.first >= 0) check($sformatf("first_rise ch%0d", c), first_r[c], e.first);
      if (e.hp > 0 && e.rises > 0) begin
         check($sformatf("high_min ch%0d", c), hmin[c], e.hp);
         check($sformatf("high_max ch%0d", c), hmax[c], e.hp);
      end
      if (e.hp > 0 && e.rises > 1) begin
         check($sformatf("period_min ch%0d", c), pmin[c], 2 * e.hp);
         check($sformatf("period_max ch%0d", c), pmax[c], 2 * e.hp);
      end
      check($sformatf("endsw ch%0d", c), endsw_ob[c], e.endsw);
      check($sformatf("fault ch%0d", c), fault_ob[c], e.fault);
      check($sformatf("aborted ch%0d", c), aborted_ob[c], e.abrt);
      clr_trk(c);
   endfunction

   always @(negedge clk_ik) begin
      if (!rst_in) begin
         for (int c = 0; c < NM; c++) clr_trk(c);
         prev_clk = '0;
      end else begin
         for (int c = 0; c < NM; c++) begin
            if (pl_clk_ob[c] && !prev_clk[c]) begin
               rises[c]++;
               if (first_r[c] < 0) first_r[c] = cyc;
               if (last_r[c] >= 0) begin
                  if (cyc - last_r[c] < pmin[c]) pmin[c] = cyc - last_r[c];
                  if (cyc - last_r[c] > pmax[c]) pmax[c] = cyc - last_r[c];
               end
               last_r[c] = cyc;
               hi_len[c] = 1;
            end else if (pl_clk_ob[c]) begin
               hi_len[c]++;
            end else if (prev_clk[c]) begin
               if (hi_len[c] < hmin[c]) hmin[c] = hi_len[c];
               if (hi_len[c] > hmax[c]) hmax[c] = hi_len[c];
            end
            if (done_ob[c]) score(c);
         end
         prev_clk = pl_clk_ob;
      end
   end

   task automatic tick();
      @(posedge clk_ik);
      #1;
   endtask

   task automatic wait_cyc(input int e);
      int guard = 0;
      while (cyc < e && guard < 100000) begin
         tick();
         guard++;
      end
   endtask

   task automatic send(input int ch, input int steps, input bit dir, input int hp,
                       input bit boost, input bit exp_ready, output int k);
      cmd_ch_ib    = 4'(ch);
      cmd_steps_ib = 32'(steps);
      cmd_dir_i    = dir;
      cmd_hp_ib    = 16'(hp);
      cmd_boost_i  = boost;
      cmd_valid_i  = 1'b1;
      #1;
      check($sformatf("cmd_ready ch%0d", ch), cmd_ready_o, exp_ready);
      k = cyc;
      tick();
      cmd_valid_i = 1'b0;
   endtask

   task automatic drain(input int max_cyc);
      int n = 0;
      while (sb.size() != 0 && n < max_cyc) begin
         tick();
         n++;
      end
      check("scoreboard_drain", sb.size(), 0);
   endtask

   initial begin
      int k, k1, k2, kx;
      cmd_valid_i = 1'b0; cmd_ch_ib = '0; cmd_steps_ib = '0; cmd_dir_i = 1'b0;
      cmd_hp_ib = '0; cmd_boost_i = 1'b0; abort_ib = '0;
      pl_pfail_ib = '0; pl_sw_outa_ib = '0; pl_sw_outb_ib = '0;

      repeat (3) tick();
      check("rst pl_clk", pl_clk_ob, 0);
      check("rst pl_dir", pl_dir_ob, 0);
      check("rst pl_en", pl_en_ob, 0);
      check("rst pl_boost", pl_boost_ob, 0);
      check("rst busy", busy_ob, 0);
      check("rst done", done_ob, 0);
      check("rst flags", {endsw_ob, fault_ob, aborted_ob}, 0);

      rst_in = 1'b1;
      repeat (4) tick();
      cmd_ch_ib = 4'd0;  #1; check("ready ch0 idle", cmd_ready_o, 1);
      cmd_ch_ib = 4'd12; #1; check("ready ch12", cmd_ready_o, 0);
      cmd_ch_ib = 4'd15; #1; check("ready ch15", cmd_ready_o, 0);
      cmd_ch_ib = 4'd12; cmd_valid_i = 1'b1;
      tick();
      cmd_valid_i = 1'b0;
      tick();
      check("busy after ch12 cmd", busy_ob, 0);

      // basic move: ch3, 4 steps, hp 5, dir 1, boost
      send(3, 4, 1, 5, 1, 1, k);
      expect_done(3, k + 49, 4, k + 9, 5, 0, 0, 0);
      check("basic pl_dir k+1", pl_dir_ob[3], 1);
      check("basic pl_en k+1", pl_en_ob[3], 1);
      check("basic busy k+1", busy_ob, 12'h008);
      check("basic ready k+1", cmd_ready_o, 0);
      check("basic boost in setup", pl_boost_ob[3], 0);
      wait_cyc(k + 10);
      check("basic pl_clk k+10", pl_clk_ob[3], 1);
      check("basic boost in high", pl_boost_ob[3], 1);
      wait_cyc(k + 20);
      send(3, 1, 0, 1, 0, 0, kx);
      check("busy cmd dir unchanged", pl_dir_ob[3], 1);
      check("busy cmd others idle", busy_ob, 12'h008);
      drain(100);
      tick();
      check("dir held after move", pl_dir_ob[3], 1);
      check("en off after move", pl_en_ob[3], 0);

      // zero steps and zero half-period
      send(0, 0, 1, 4, 0, 1, k);
      expect_done(0, k + 9, 0, -1, 0, 0, 0, 0);
      drain(50);
      send(1, 3, 0, 0, 0, 1, k);
      expect_done(1, k + 15, 3, k + 9, 1, 0, 0, 0);
      drain(50);

      // dir 0 ignores switch A
      pl_sw_outa_ib[5] = 1'b1;
      send(5, 3, 0, 2, 0, 1, k);
      expect_done(5, k + 21, 3, k + 9, 2, 0, 0, 0);
      drain(60);
      pl_sw_outa_ib[5] = 1'b0;

      // switch B raised during the 3rd high phase: pulse completes, no 4th rise
      send(5, 100, 0, 2, 0, 1, k);
      expect_done(5, k + 21, 3, k + 9, 2, 1, 0, 0);
      wait_cyc(k + 18);
      pl_sw_outb_ib[5] = 1'b1;
      drain(100);
      pl_sw_outb_ib[5] = 1'b0;

      // pfail mid-HIGH
      send(7, 10, 1, 6, 1, 1, k);
      expect_done(7, k + 13, 1, k + 9, 0, 0, 1, 0);
      wait_cyc(k + 10);
      pl_pfail_ib[7] = 1'b1;
      wait_cyc(k + 12);
      check("pfail clk still high", pl_clk_ob[7], 1);
      tick();
      check("pfail clk dropped", pl_clk_ob[7], 0);
      check("pfail boost dropped", pl_boost_ob[7], 0);
      drain(50);
      pl_pfail_ib[7] = 1'b0;

      // pfail and abort reaching the FSM on the same edge (abort is not
      // synchronised, so it is raised two cycles after pfail)
      send(8, 10, 0, 3, 0, 1, k);
      expect_done(8, k + 13, 1, k + 9, 0, 0, 1, 0);
      wait_cyc(k + 10);
      pl_pfail_ib[8] = 1'b1;
      wait_cyc(k + 12);
      abort_ib[8] = 1'b1;
      drain(50);
      abort_ib[8] = 1'b0;
      pl_pfail_ib[8] = 1'b0;

      // abort alone, during LOW
      send(9, 10, 1, 3, 0, 1, k);
      expect_done(9, k + 13, 1, k + 9, 0, 0, 0, 1);
      wait_cyc(k + 12);
      abort_ib[9] = 1'b1;
      tick();
      abort_ib[9] = 1'b0;
      drain(50);

      // two channels on consecutive cycles
      send(10, 2, 1, 3, 0, 1, k1);
      send(11, 3, 0, 1, 0, 1, k2);
      expect_done(10, k1 + 21, 2, k1 + 9, 3, 0, 0, 0);
      expect_done(11, k2 + 15, 3, k2 + 9, 1, 0, 0, 0);
      wait_cyc(k2 + 10);
      check("concurrent busy", busy_ob[11:10], 2'b11);
      check("concurrent dir", pl_dir_ob[11:10], 2'b01);
      drain(100);

      // command accepted while pfail held: ends after SETUP's first cycle
      pl_pfail_ib[2] = 1'b1;
      repeat (3) tick();
      send(2, 5, 1, 2, 0, 1, k);
      expect_done(2, k + 2, 0, -1, 0, 0, 1, 0);
      drain(50);
      pl_pfail_ib[2] = 1'b0;

      repeat (3) tick();
      check("sticky endsw", endsw_ob, 12'h020);
      check("sticky fault", fault_ob, 12'h184);
      check("sticky aborted", aborted_ob, 12'h200);

      // reset in the middle of a move
      send(4, 50, 1, 3, 1, 1, k);
      wait_cyc(k + 10);
      check("pre-reset clk high", pl_clk_ob[4], 1);
      #2;
      rst_in = 1'b0;
      #1;
      check("async rst pl_clk", pl_clk_ob, 0);
      check("async rst pl_en", pl_en_ob, 0);
      check("async rst pl_dir", pl_dir_ob, 0);
      check("async rst busy", busy_ob, 0);
      check("async rst flags", {endsw_ob, fault_ob, aborted_ob}, 0);
      repeat (2) tick();
      rst_in = 1'b1;
      repeat (4) tick();
      send(4, 2, 0, 2, 0, 1, k);
      expect_done(4, k + 17, 2, k + 9, 2, 0, 0, 0);
      drain(60);
      check("post-reset flags", {endsw_ob, fault_ob, aborted_ob}, 0);

      repeat (3) tick();
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
